// File: rtl/au_pipe_if.sv
// Request/response bundle for au_pipe: operand request with valid/ready,
// result response with valid/ready, plus status flags.
interface au_pipe_if #(
  parameter int W    = 24,
  parameter int TAGW = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [W-1:0]    a_in;
  logic [W-1:0]    b_in;
  logic [TAGW-1:0] tag_in;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    result;
  logic [TAGW-1:0] tag_out;
  logic            sat;
  logic            div0;
  logic            busy;

  // Requester / consumer side (operand router + writeback).
  modport master (
    output in_valid, op, a_in, b_in, tag_in, out_ready,
    input  in_ready, out_valid, result, tag_out, sat, div0, busy
  );

  // Arithmetic unit side.
  modport slave (
    input  in_valid, op, a_in, b_in, tag_in, out_ready,
    output in_ready, out_valid, result, tag_out, sat, div0, busy
  );
endinterface

// File: rtl/au_pipe.sv
// au_pipe: sign-magnitude fixed-point ADD/SUB/MUL/DIV unit with valid/ready
// handshakes and a tag. ADD/SUB/MUL and divide-by-zero finish in one cycle;
// DIV runs a restoring divider, one quotient bit per cycle.
// Build option: define AU_ROUND_EN for round-to-nearest (ties away from zero)
// on MUL and DIV; otherwise both truncate toward zero.
module au_pipe #(
  parameter int W    = 24,
  parameter int FRAC = 14,
  parameter int TAGW = 4
) (
  input logic       clk,
  input logic       rst_n,
  au_pipe_if.slave  bus
);

  localparam int M  = W - 1;          // magnitude width
  localparam int N  = M + FRAC;       // quotient width / divide iterations
  localparam int CW = $clog2(N);
  localparam logic [M-1:0] MAG_MAX = '1;
`ifdef AU_ROUND_EN
  localparam logic [2*M-1:0] MUL_RND = (2*M)'(1) << (FRAC - 1);
`else
  localparam logic [2*M-1:0] MUL_RND = '0;
`endif

  typedef enum logic [1:0] {IDLE, DIVIT, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01,
                            OP_MUL = 2'b10, OP_DIV = 2'b11} op_t;

  state_t          state_q, state_d;
  logic [M-1:0]    rem_q, rem_d, dsr_q, dsr_d;
  logic [N-1:0]    quo_q, quo_d;
  logic            sgn_q, sgn_d;
  logic [TAGW-1:0] tagl_q, tagl_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ov_q, ov_d;
  logic [W-1:0]    res_q, res_d;
  logic [TAGW-1:0] tago_q, tago_d;
  logic            sat_q, sat_d, div0_q, div0_d;

  // Operand decode; a zero magnitude is always treated as +0.
  logic [M-1:0] r_mag, s_mag;
  logic         r_s, s_s, accept, fast;
  op_t          op;

  assign r_mag = bus.a_in[M-1:0];
  assign s_mag = bus.b_in[M-1:0];
  assign r_s   = bus.a_in[W-1] & (|r_mag);
  assign s_s   = bus.b_in[W-1] & (|s_mag);
  assign op    = op_t'(bus.op);
  assign fast  = (op != OP_DIV) || (s_mag == '0);

  assign bus.in_ready  = rst_n & (state_q == IDLE) & (!ov_q | bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = ov_q;
  assign bus.result    = res_q;
  assign bus.tag_out   = tago_q;
  assign bus.sat       = sat_q;
  assign bus.div0      = div0_q;
  assign bus.busy      = (state_q == DIVIT);

  // Single-cycle datapath: ADD/SUB in W+1-bit two's complement, MUL, DIV-by-zero.
  logic [W:0]     ta, tb, sum, sabs;
  logic           tb_neg;
  logic [2*M-1:0] prod, prod_sh;
  logic [M-1:0]   f_mag;
  logic           f_sgn, f_sat, f_div0;

  always_comb begin
    tb_neg  = s_s ^ (op == OP_SUB);
    ta      = ({2'b00, r_mag} ^ {(W+1){r_s}}) + (W+1)'(r_s);
    tb      = ({2'b00, s_mag} ^ {(W+1){tb_neg}}) + (W+1)'(tb_neg);
    sum     = ta + tb;
    sabs    = sum[W] ? (~sum + (W+1)'(1)) : sum;
    prod    = ({{M{1'b0}}, r_mag} * {{M{1'b0}}, s_mag}) + MUL_RND;
    prod_sh = prod >> FRAC;
    f_mag   = '0;
    f_sgn   = 1'b0;
    f_sat   = 1'b0;
    f_div0  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        f_sgn = sum[W];
        if (|sabs[W:M]) begin
          f_mag = MAG_MAX;
          f_sat = 1'b1;
        end else begin
          f_mag = sabs[M-1:0];
        end
      end
      OP_MUL: begin
        f_sgn = r_s ^ s_s;
        if (|prod_sh[2*M-1:M]) begin
          f_mag = MAG_MAX;
          f_sat = 1'b1;
        end else begin
          f_mag = prod_sh[M-1:0];
        end
      end
      default: begin
        // Only reached for S_mag==0; 0/0 leaves magnitude and sat at zero.
        f_div0 = 1'b1;
        f_sgn  = r_s;
        if (r_mag != '0) begin
          f_mag = MAG_MAX;
          f_sat = 1'b1;
        end
      end
    endcase
  end

  // Restoring-division step and the final rounding/saturation of the quotient.
  logic [M:0]   trial;
  logic [M-1:0] diff, d_mag;
  logic         ge, rnd, d_sat;
  logic [N:0]   qr;

  always_comb begin
    trial = {rem_q, quo_q[N-1]};
    ge    = trial >= {1'b0, dsr_q};
    // When ge, trial - S < S fits in M bits, so the low-M difference is exact.
    diff  = trial[M-1:0] - dsr_q;
`ifdef AU_ROUND_EN
    rnd   = {rem_q, 1'b0} >= {1'b0, dsr_q};
`else
    rnd   = 1'b0;
`endif
    qr    = {1'b0, quo_q} + (N+1)'(rnd);
    d_sat = |qr[N:M];
    d_mag = d_sat ? MAG_MAX : qr[M-1:0];
  end

  // Next-state logic for the FSM, divider registers and output register.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    sgn_d   = sgn_q;
    tagl_d  = tagl_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    res_d   = res_q;
    tago_d  = tago_q;
    sat_d   = sat_q;
    div0_d  = div0_q;
    if (ov_q & bus.out_ready) ov_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (fast) begin
            ov_d   = 1'b1;
            res_d  = {f_sgn & (|f_mag), f_mag};
            tago_d = bus.tag_in;
            sat_d  = f_sat;
            div0_d = f_div0;
          end else begin
            rem_d   = '0;
            quo_d   = {r_mag, {FRAC{1'b0}}};
            dsr_d   = s_mag;
            sgn_d   = r_s ^ s_s;
            tagl_d  = bus.tag_in;
            cnt_d   = '0;
            state_d = DIVIT;
          end
        end
      end
      DIVIT: begin
        rem_d = ge ? diff : trial[M-1:0];
        quo_d = {quo_q[N-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = DONE;
      end
      DONE: begin
        ov_d    = 1'b1;
        res_d   = {sgn_q & (|d_mag), d_mag};
        tago_d  = tagl_q;
        sat_d   = d_sat;
        div0_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Divider working registers and output holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      sgn_q  <= 1'b0;
      tagl_q <= '0;
      cnt_q  <= '0;
      ov_q   <= 1'b0;
      res_q  <= '0;
      tago_q <= '0;
      sat_q  <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
      sgn_q  <= sgn_d;
      tagl_q <= tagl_d;
      cnt_q  <= cnt_d;
      ov_q   <= ov_d;
      res_q  <= res_d;
      tago_q <= tago_d;
      sat_q  <= sat_d;
      div0_q <= div0_d;
    end
  end

endmodule

// File: doc/au_pipe.md
Name: au_pipe

Overview:
- Second-generation sign-magnitude fixed-point arithmetic unit for the Kalman datapath. Fully parametrised in word width, fraction bits and tag width.
- Supports ADD, SUB, MUL and a true quotient DIV (R/S, not R·(1/S)).
- Uses a valid/ready handshake on both input and output, carries a transaction tag, and reports saturation and divide-by-zero flags.
- Sits between the operand router and the result writeback, replacing the start/done style unit.

Parameters:
- W, 24, total word width; bit W-1 is the sign, bits W-2:0 are the magnitude.
- FRAC, 14, number of fractional magnitude bits; must satisfy 1 <= FRAC <= W-2.
- TAGW, 4, width of the opaque tag passed from input to output.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit accepts the request this cycle.
- op  in  2  operation: 00=ADD, 01=SUB, 10=MUL, 11=DIV.
- a_in  in  W  operand R, sign-magnitude.
- b_in  in  W  operand S, sign-magnitude.
- tag_in  in  TAGW  opaque tag.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer takes the result.
- result  out  W  sign-magnitude result.
- tag_out  out  TAGW  tag of the result.
- sat  out  1  result magnitude was clamped to MAG_MAX.
- div0  out  1  DIV with S magnitude 0.
- busy  out  1  DIV iteration in progress.

Behaviour:
- MAG_MAX = 2^(W-1)-1. Transfer occurs on in_valid & in_ready, or on out_valid & out_ready.
- Reset (async assert, synchronous release):
  - FSM returns to IDLE.
  - out_valid, result, tag_out, sat, div0 and busy all clear to 0.
  - in_ready is 0 while rst_n is low.
  - An in-flight DIV is discarded with no output.
- Only one operation is in flight at a time.
  - in_ready = (state==IDLE) & (!out_valid | out_ready), so an accept may coincide with a drain.
- FSM states:
  - IDLE: on accept of ADD, SUB, MUL, or a DIV with S_mag==0, compute combinationally and load the output register at the same edge. State stays IDLE; out_valid=1 from the next cycle. Latency is 1.
  - IDLE: on accept of a DIV with S_mag!=0, latch operands, sign and tag, then go to DIVIT.
  - DIVIT: restoring long division of (R_mag << FRAC) by S_mag, one quotient bit per cycle, N = W-1+FRAC cycles. busy=1.
  - DIVIT to DONE after N iterations.
  - DONE: load the output register and go to IDLE. out_valid asserts N+1 cycles after the accept edge (38 at the defaults). in_ready is 0 throughout DIVIT and DONE.
- Output register: holds result, tag_out, sat and div0 stable while out_valid & !out_ready. out_valid clears on drain unless a new 1-cycle result loads at the same edge.
- ADD/SUB: convert to two's complement at W+1 bits, add or subtract, convert back to sign-magnitude, saturate the magnitude to MAG_MAX and set sat.
- MUL:
  - Sign = sR ^ sS.
  - Full 2(W-1)-bit magnitude product, shifted right by FRAC (rounding per the optional feature).
  - If the shifted value exceeds MAG_MAX, clamp and set sat.
- DIV:
  - Sign = sR ^ sS.
  - Quotient is W-1+FRAC bits; if any bit above W-2 is set, or rounding carries past MAG_MAX, clamp and set sat.
  - S_mag==0 with R_mag!=0: result {sR, MAG_MAX}, div0=1, sat=1.
  - 0/0: result 0, div0=1, sat=0.
- Negative zero:
  - Inputs with magnitude 0 are treated as +0.
  - Any result with magnitude 0 is emitted with sign 0.
- op is sampled only at accept; changes to inputs during DIVIT have no effect.

Optional Feature:
- AU_ROUND_EN defined: MUL and DIV round to nearest, ties away from zero in magnitude.
  - MUL adds 2^(FRAC-1) to the product before the shift.
  - DIV adds 1 to the quotient when 2*remainder >= S_mag.
  - DIV latency is unchanged; the round step occurs in DONE.
- AU_ROUND_EN undefined: MUL and DIV truncate the magnitude, i.e. round toward zero.

Test Plan:
- ADD 0x006000 (+1.5) + 0x808000 (-2.0) -> result 0x802000, sat=0, out_valid one cycle after accept.
- MUL 0x006000 × 0x808000 -> 0x80C000; MUL 0x7FFFFF × 0x008000 -> 0x7FFFFF with sat=1.
- DIV 0x008000 / 0x00C000 -> 0x002AAA without AU_ROUND_EN, 0x002AAB with it. busy=1 for 37 cycles, out_valid at accept+38, in_ready=0 throughout.
- DIV 0x804000 / 0x000000 -> 0xFFFFFF, div0=1, sat=1, 1-cycle latency; DIV 0x000000 / 0x800000 -> 0x000000, div0=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after a SUB result: result and tag_out stay stable and in_ready=0.
  - Then raise out_ready together with a new in_valid ADD: the drain and accept happen at the same edge, and the new result appears next cycle with the new tag.
- Reset mid-DIV: drop rst_n 10 cycles into DIVIT -> out_valid, busy and result clear immediately; after release in_ready=1 and no stale result ever appears.
